// File: rtl/bit64_add_pipe_pkg.sv
// Shared ANC arithmetic definitions: sample type, half-word type and the
// saturation limits used when a signed sum overflows.
package bit64_add_pipe_pkg;

  localparam int DATA_W = 64;
  localparam int HALF_W = 32;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic        [HALF_W-1:0] half_t;

  localparam sample_t SAT_POS = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam sample_t SAT_NEG = 64'sh8000_0000_0000_0000;

  // Clamp value follows the common operand sign (both signs agree on overflow).
  function automatic sample_t sat_value(input logic neg);
    return neg ? SAT_NEG : SAT_POS;
  endfunction

endpackage

// File: rtl/bit64_add_pipe_add32_carry.sv
// Registered 32-bit adder with carry in/out; the result only updates when en
// is high, so a stalled stage keeps its sum.
module add32_carry
  import bit64_add_pipe_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  half_t a,
  input  half_t b,
  input  logic  cin,
  output half_t sum,
  output logic  cout
);

  logic [HALF_W:0] total_next;

  assign total_next = {1'b0, a} + {1'b0, b} + {{HALF_W{1'b0}}, cin};

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (en) begin
      {cout, sum} <= total_next;
    end
  end

endmodule

// File: rtl/bit64_add_pipe.sv
// Two-stage 64-bit signed adder with valid/ready handshake: S1 adds the low
// halves, S2 adds the high halves with the carry and applies overflow handling.
module bit64_add_pipe
  import bit64_add_pipe_pkg::*;
#(
  parameter int SATURATE = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  output logic    in_ready,
  input  sample_t in1,
  input  sample_t in2,
  output logic    out_valid,
  input  logic    out_ready,
  output sample_t out1,
  output logic    ovf
);

  logic  s1_valid_reg, s1_valid_next;
  logic  s2_valid_reg, s2_valid_next;
  logic  s1_load, s2_load, s2_free;

  half_t s1_lo;
  logic  s1_carry;
  half_t hi1_reg, hi2_reg;

  half_t s2_hi;
  logic  s2_cout;
  half_t lo2_reg;
  logic  sign1_reg, sign2_reg;

  logic    ovf_raw;
  sample_t wrapped;

  // S2 can take a new sample when empty or when it is emptying this cycle.
  assign s2_free  = !s2_valid_reg || out_ready;
  assign in_ready = !s1_valid_reg || !s2_valid_reg || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid_reg && s2_free;

  add32_carry u_add_lo (
    .clk  (clk),
    .rst  (rst),
    .en   (s1_load),
    .a    (in1[HALF_W-1:0]),
    .b    (in2[HALF_W-1:0]),
    .cin  (1'b0),
    .sum  (s1_lo),
    .cout (s1_carry)
  );

  add32_carry u_add_hi (
    .clk  (clk),
    .rst  (rst),
    .en   (s2_load),
    .a    (hi1_reg),
    .b    (hi2_reg),
    .cin  (s1_carry),
    .sum  (s2_hi),
    .cout (s2_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hi1_reg   <= '0;
      hi2_reg   <= '0;
      lo2_reg   <= '0;
      sign1_reg <= 1'b0;
      sign2_reg <= 1'b0;
    end else begin
      if (s1_load) begin
        hi1_reg <= in1[DATA_W-1:HALF_W];
        hi2_reg <= in2[DATA_W-1:HALF_W];
      end
      if (s2_load) begin
        lo2_reg   <= s1_lo;
        sign1_reg <= hi1_reg[HALF_W-1];
        sign2_reg <= hi2_reg[HALF_W-1];
      end
    end
  end

  always_comb begin
    s1_valid_next = s1_valid_reg;
    s2_valid_next = s2_valid_reg;
    if (s1_load) begin
      s1_valid_next = 1'b1;
    end else if (s2_load) begin
      s1_valid_next = 1'b0;
    end
    if (s2_load) begin
      s2_valid_next = 1'b1;
    end else if (out_ready) begin
      s2_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= s1_valid_next;
      s2_valid_reg <= s2_valid_next;
    end
  end

  // Overflow = carry into bit 63 xor carry out of bit 63; the carry into bit
  // 63 is recovered from the sum bit and the two operand sign bits.
  assign ovf_raw = s2_cout ^ s2_hi[HALF_W-1] ^ sign1_reg ^ sign2_reg;
  assign wrapped = {s2_hi, lo2_reg};

  assign out1      = ((SATURATE != 0) && ovf_raw) ? sat_value(sign1_reg) : wrapped;
  assign ovf       = ovf_raw;
  assign out_valid = s2_valid_reg && !rst;

endmodule
